// File: rtl/lfsr_link_exerciser.sv
// lfsr_link_exerciser: stimulus sequencer for the LFSR generator/checker link.
// One start pulse runs seed load, lock acquisition, a corruption burst,
// confirmation of lock loss and re-lock, then reports the result.
module lfsr_link_exerciser #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_seed_cfg,
    input  logic [3:0] i_inject_len,
    input  logic       i_lock,
    output logic       o_valid,
    output logic [7:0] o_seed,
    output logic       o_soft_rst,
    output logic       o_corrupt,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [7:0] o_lock_cycles,
    output logic [7:0] o_unlock_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        ACQUIRE,
        INJECT,
        WAIT_UNLOCK,
        RELOCK,
        DONE
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] cnt;
    logic       unl_seen;
    logic [3:0] len_q;

    logic [8:0] cnt_inc;
    logic       timeout_hit;
    logic       inject_last;

    logic       valid_d;
    logic       soft_rst_d;
    logic       corrupt_d;
    logic       busy_d;
    logic       done_d;

    // The counter sum is one bit wider so a limit of 255 compares cleanly.
    assign cnt_inc     = {1'b0, cnt} + 9'd1;
    assign timeout_hit = (cnt_inc >= {1'b0, TIMEOUT});
    assign inject_last = (cnt_inc >= {5'b0, len_q});

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision; lock takes priority over an expiring timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    next_state = SEED;
                end
            end
            SEED: begin
                next_state = ACQUIRE;
            end
            ACQUIRE: begin
                if (i_lock) begin
                    next_state = (len_q == 4'd0) ? DONE : INJECT;
                end else if (timeout_hit) begin
                    next_state = DONE;
                end
            end
            INJECT: begin
                if (inject_last) begin
                    next_state = (unl_seen || !i_lock) ? RELOCK : WAIT_UNLOCK;
                end
            end
            WAIT_UNLOCK: begin
                if (!i_lock) begin
                    next_state = RELOCK;
                end else if (timeout_hit) begin
                    next_state = DONE;
                end
            end
            RELOCK: begin
                if (i_lock || timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Strobe decode from the upcoming state so the registered strobes line up with it.
    always_comb begin
        valid_d    = 1'b0;
        soft_rst_d = 1'b0;
        corrupt_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (next_state)
            SEED: begin
                soft_rst_d = 1'b1;
                busy_d     = 1'b1;
            end
            ACQUIRE, WAIT_UNLOCK, RELOCK: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            INJECT: begin
                valid_d   = 1'b1;
                corrupt_d = 1'b1;
                busy_d    = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_soft_rst <= 1'b0;
            o_corrupt  <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_valid    <= valid_d;
            o_soft_rst <= soft_rst_d;
            o_corrupt  <= corrupt_d;
            o_busy     <= busy_d;
            o_done     <= done_d;
        end
    end

    // Phase counter, latched configuration and run results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt             <= 8'd0;
            unl_seen        <= 1'b0;
            len_q           <= 4'd0;
            o_seed          <= 8'd0;
            o_pass          <= 1'b0;
            o_lock_cycles   <= 8'd0;
            o_unlock_cycles <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_seed          <= i_seed_cfg;
                        len_q           <= i_inject_len;
                        o_pass          <= 1'b0;
                        o_lock_cycles   <= 8'd0;
                        o_unlock_cycles <= 8'd0;
                        unl_seen        <= 1'b0;
                    end
                end
                SEED: begin
                    cnt <= 8'd0;
                end
                ACQUIRE: begin
                    cnt <= cnt_inc[7:0];
                    if (i_lock) begin
                        o_lock_cycles <= cnt_inc[7:0];
                        if (len_q == 4'd0) begin
                            o_pass <= 1'b1;
                        end else begin
                            cnt <= 8'd0;
                        end
                    end
                end
                INJECT: begin
                    cnt <= cnt_inc[7:0];
                    if (!i_lock && !unl_seen) begin
                        o_unlock_cycles <= cnt_inc[7:0];
                        unl_seen        <= 1'b1;
                    end
                    if (inject_last && (unl_seen || !i_lock)) begin
                        cnt <= 8'd0;
                    end
                end
                WAIT_UNLOCK: begin
                    cnt <= cnt_inc[7:0];
                    if (!i_lock) begin
                        o_unlock_cycles <= cnt_inc[7:0];
                        unl_seen        <= 1'b1;
                        cnt             <= 8'd0;
                    end
                end
                RELOCK: begin
                    cnt <= cnt_inc[7:0];
                    if (i_lock) begin
                        o_pass <= 1'b1;
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule
